// File: rtl/kf_update_semipar.sv
// 2x2 Kalman measurement update: innovation, posterior state and posterior
// covariance, computed on four shared multipliers over a fixed 12-step schedule.
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

module kf_update_semipar #(
  parameter int unsigned N    = `FXP_N,
  parameter int unsigned FRAC = `FXP_FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x_prior0,
  input  logic [N-1:0] x_prior1,
  input  logic [N-1:0] z0,
  input  logic [N-1:0] z1,
  input  logic [N-1:0] h00,
  input  logic [N-1:0] h01,
  input  logic [N-1:0] h10,
  input  logic [N-1:0] h11,
  input  logic [N-1:0] K00,
  input  logic [N-1:0] K01,
  input  logic [N-1:0] K10,
  input  logic [N-1:0] K11,
  input  logic [N-1:0] p_prior00,
  input  logic [N-1:0] p_prior01,
  input  logic [N-1:0] p_prior10,
  input  logic [N-1:0] p_prior11,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] x_post0,
  output logic [N-1:0] x_post1,
  output logic [N-1:0] P_post00,
  output logic [N-1:0] P_post01,
  output logic [N-1:0] P_post10,
  output logic [N-1:0] P_post11
);

  localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1} << FRAC;

  // Keep the integer part of a 2N-bit product sum; arithmetic shift = floor.
  function automatic logic [N-1:0] trunc(input logic [2*N-1:0] v);
    return v[FRAC+N-1:FRAC];
  endfunction

  logic [3:0]            cyc_q;
  logic signed [N-1:0]   op_a_q [4];
  logic signed [N-1:0]   op_b_q [4];
  logic signed [N-1:0]   mul_a_d [4];
  logic signed [N-1:0]   mul_b_d [4];
  logic signed [2*N-1:0] prod [4];
  logic [2*N-1:0]        sum01, sum23;
  logic [N-1:0]          t01, t23;
  logic [N-1:0]          y0_q, y1_q;
  logic [N-1:0]          a00_q, a01_q, a10_q, a11_q;

  // Full-width products and the two column adders (carry out of 2N dropped).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      prod[i] = (2*N)'(op_a_q[i]) * (2*N)'(op_b_q[i]);
    end
    sum01 = prod[0] + prod[1];
    sum23 = prod[2] + prod[3];
    t01   = trunc(sum01);
    t23   = trunc(sum23);
  end

  // Operand selection for the even (multiplier-load) steps.
  always_comb begin
    mul_a_d = op_a_q;
    mul_b_d = op_b_q;
    case (cyc_q)
      4'd0: begin
        mul_a_d = '{h00, h01, h10, h11};
        mul_b_d = '{x_prior0, x_prior1, x_prior0, x_prior1};
      end
      4'd2: begin
        mul_a_d = '{K00, K01, K10, K11};
        mul_b_d = '{y0_q, y1_q, y0_q, y1_q};
      end
      4'd4: begin
        mul_a_d = '{K00, K01, K10, K11};
        mul_b_d = '{h00, h10, h00, h10};
      end
      4'd6: begin
        mul_a_d = '{K00, K01, K10, K11};
        mul_b_d = '{h01, h11, h01, h11};
      end
      4'd8: begin
        mul_a_d = '{a00_q, a01_q, a10_q, a11_q};
        mul_b_d = '{p_prior00, p_prior10, p_prior00, p_prior10};
      end
      4'd10: begin
        mul_a_d = '{a00_q, a01_q, a10_q, a11_q};
        mul_b_d = '{p_prior01, p_prior11, p_prior01, p_prior11};
      end
      default: ;
    endcase
  end

  // Handshake, step counter, operand registers and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      cyc_q <= '0;
      for (int i = 0; i < 4; i++) begin
        op_a_q[i] <= '0;
        op_b_q[i] <= '0;
      end
      y0_q     <= '0;
      y1_q     <= '0;
      a00_q    <= '0;
      a01_q    <= '0;
      a10_q    <= '0;
      a11_q    <= '0;
      x_post0  <= '0;
      x_post1  <= '0;
      P_post00 <= '0;
      P_post01 <= '0;
      P_post10 <= '0;
      P_post11 <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy  <= 1'b1;
          cyc_q <= '0;
        end
      end else begin
        cyc_q <= cyc_q + 4'd1;
        if (!cyc_q[0]) begin
          op_a_q <= mul_a_d;
          op_b_q <= mul_b_d;
        end
        case (cyc_q)
          4'd1: begin
            y0_q <= z0 - t01;
            y1_q <= z1 - t23;
          end
          4'd3: begin
            x_post0 <= x_prior0 + t01;
            x_post1 <= x_prior1 + t23;
          end
          4'd5: begin
            a00_q <= One - t01;
            a10_q <= '0 - t23;
          end
          4'd7: begin
            a01_q <= '0 - t01;
            a11_q <= One - t23;
          end
          4'd9: begin
            P_post00 <= t01;
            P_post10 <= t23;
          end
          4'd11: begin
            P_post01 <= t01;
            P_post11 <= t23;
          end
          default: ;
        endcase
        if (cyc_q == 4'd11) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_kf_update_semipar.sv
// Self-checking bench for kf_update_semipar: frame-level matrix model plus
// directed literal cases and randomized frames.
module tb_kf_update_semipar;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] x_prior0, x_prior1, z0, z1, h00, h01, h10, h11;
  logic [15:0] K00, K01, K10, K11, p_prior00, p_prior01, p_prior10, p_prior11;
  logic        busy, done;
  logic [15:0] x_post0, x_post1, P_post00, P_post01, P_post10, P_post11;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  kf_update_semipar #(.N(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_prior0(x_prior0), .x_prior1(x_prior1), .z0(z0), .z1(z1),
    .h00(h00), .h01(h01), .h10(h10), .h11(h11),
    .K00(K00), .K01(K01), .K10(K10), .K11(K11),
    .p_prior00(p_prior00), .p_prior01(p_prior01),
    .p_prior10(p_prior10), .p_prior11(p_prior11),
    .busy(busy), .done(done),
    .x_post0(x_post0), .x_post1(x_post1),
    .P_post00(P_post00), .P_post01(P_post01),
    .P_post10(P_post10), .P_post11(P_post11)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic longint sx(input logic [15:0] v);
    return longint'(signed'(v));
  endfunction

  // Keep 32 bits of the sum, take bits [23:8] (floor division by 256).
  function automatic logic [15:0] tr(input longint s);
    logic [31:0] w;
    w = s[31:0];
    return w[23:8];
  endfunction

  logic [15:0] g_x0, g_x1, g_p00, g_p01, g_p10, g_p11;

  task automatic golden();
    logic [15:0] y0, y1, a00, a01, a10, a11;
    y0    = z0 - tr(sx(h00) * sx(x_prior0) + sx(h01) * sx(x_prior1));
    y1    = z1 - tr(sx(h10) * sx(x_prior0) + sx(h11) * sx(x_prior1));
    g_x0  = x_prior0 + tr(sx(K00) * sx(y0) + sx(K01) * sx(y1));
    g_x1  = x_prior1 + tr(sx(K10) * sx(y0) + sx(K11) * sx(y1));
    a00   = 16'h0100 - tr(sx(K00) * sx(h00) + sx(K01) * sx(h10));
    a01   = 16'h0000 - tr(sx(K00) * sx(h01) + sx(K01) * sx(h11));
    a10   = 16'h0000 - tr(sx(K10) * sx(h00) + sx(K11) * sx(h10));
    a11   = 16'h0100 - tr(sx(K10) * sx(h01) + sx(K11) * sx(h11));
    g_p00 = tr(sx(a00) * sx(p_prior00) + sx(a01) * sx(p_prior10));
    g_p10 = tr(sx(a10) * sx(p_prior00) + sx(a11) * sx(p_prior10));
    g_p01 = tr(sx(a00) * sx(p_prior01) + sx(a01) * sx(p_prior11));
    g_p11 = tr(sx(a10) * sx(p_prior01) + sx(a11) * sx(p_prior11));
  endtask

  // Frame-level timing: results appear 4, 10 and 12 edges after acceptance.
  bit          m_busy = 1'b0, m_done = 1'b0;
  int          m_age = 0;
  logic [15:0] m_x0 = '0, m_x1 = '0, m_p00 = '0, m_p01 = '0, m_p10 = '0, m_p11 = '0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0; m_age = 0;
      m_x0 = '0; m_x1 = '0; m_p00 = '0; m_p01 = '0; m_p10 = '0; m_p11 = '0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_age  = 0;
      end
    end else begin
      m_age++;
      golden();
      if (m_age == 4) begin m_x0 = g_x0; m_x1 = g_x1; end
      if (m_age == 10) begin m_p00 = g_p00; m_p10 = g_p10; end
      if (m_age == 12) begin
        m_p01 = g_p01; m_p11 = g_p11;
        m_busy = 1'b0; m_done = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("x_post0", x_post0, m_x0);
      check("x_post1", x_post1, m_x1);
      check("P_post00", P_post00, m_p00);
      check("P_post01", P_post01, m_p01);
      check("P_post10", P_post10, m_p10);
      check("P_post11", P_post11, m_p11);
    end
  end

  // ---------------- stimulus ----------------
  task automatic load(input logic [15:0] a00, a01, a10, a11, k0, k1, k2, k3,
                      xa, xb, za, zb, p0, p1, p2, p3);
    h00 = a00; h01 = a01; h10 = a10; h11 = a11;
    K00 = k0; K01 = k1; K10 = k2; K11 = k3;
    x_prior0 = xa; x_prior1 = xb; z0 = za; z1 = zb;
    p_prior00 = p0; p_prior01 = p1; p_prior10 = p2; p_prior11 = p3;
  endtask

  // Issue one start and return the number of edges from acceptance to done.
  task automatic run_frame(output int lat);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) lat = k;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && busy; k++) begin
      @(posedge clk);
      #1;
    end
    check("drain idle", busy, 1'b0);
  endtask

  initial begin
    int lat;
    load('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset x_post0", x_post0, 16'h0);
    check("reset P_post11", P_post11, 16'h0);
    chk_en = 1'b1;
    @(negedge clk) rst_n = 1'b1;

    // Identity H, half gain, P=2I.
    load(16'h0100, 0, 0, 16'h0100, 16'h0080, 0, 0, 16'h0080,
         16'h0100, 16'h0200, 16'h0300, 16'h0200, 16'h0200, 0, 0, 16'h0200);
    run_frame(lat);
    check("t1 latency", lat, 12);
    check("t1 x_post0", x_post0, 16'h0200);
    check("t1 x_post1", x_post1, 16'h0200);
    check("t1 P_post00", P_post00, 16'h0100);
    check("t1 P_post11", P_post11, 16'h0100);
    check("t1 P_post01", P_post01, 16'h0000);
    check("t1 P_post10", P_post10, 16'h0000);

    // Zero gain passes prior through bit-exact.
    load(16'h1234, 16'hF00D, 16'h0777, 16'h8001, 0, 0, 0, 0,
         16'hABCD, 16'h0123, 16'h5555, 16'hAAAA, 16'h0123, 16'h0045, 16'h0045, 16'h0300);
    run_frame(lat);
    check("t2 latency", lat, 12);
    check("t2 x_post0", x_post0, 16'hABCD);
    check("t2 x_post1", x_post1, 16'h0123);
    check("t2 P_post00", P_post00, 16'h0123);
    check("t2 P_post01", P_post01, 16'h0045);
    check("t2 P_post10", P_post10, 16'h0045);
    check("t2 P_post11", P_post11, 16'h0300);

    // Floor truncation of a small negative product.
    load(16'h0100, 0, 0, 16'h0100, 16'h0080, 0, 0, 0,
         16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0100, 0, 0, 16'h0100);
    run_frame(lat);
    check("t3 x_post0 floor", x_post0, 16'hFFFF);

    // Two's-complement wrap of the state update.
    load(16'h0100, 0, 0, 16'h0100, 16'h0100, 0, 0, 16'h0100,
         16'h7F00, 16'h0000, 16'h8100, 16'h0000, 16'h0100, 0, 0, 16'h0100);
    run_frame(lat);
    check("t4 x_post0 wrap", x_post0, 16'h8100);

    // start held high: accepts every 13 cycles.
    load(16'h0100, 0, 0, 16'h0100, 16'h0080, 0, 0, 16'h0080,
         16'h0100, 16'h0200, 16'h0300, 16'h0200, 16'h0200, 0, 0, 16'h0200);
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      check("hold done", done, (i == 12 || i == 25));
      check("hold busy", busy, !(i == 12 || i == 25));
    end
    @(negedge clk) start = 1'b0;
    drain();

    // A start pulse mid-frame (step 5) is ignored.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    lat = 0;
    for (int k = 7; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (done) lat = k;
    end
    check("pulse latency", lat, 12);
    @(posedge clk);
    #1;
    check("pulse not queued", busy, 1'b0);

    // Reset at step 7 aborts the frame.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort x_post0", x_post0, 16'h0);
    check("abort x_post1", x_post1, 16'h0);
    check("abort P_post00", P_post00, 16'h0);
    check("abort P_post11", P_post11, 16'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      check("no done after abort", done, 1'b0);
    end
    run_frame(lat);
    check("post-reset latency", lat, 12);
    check("post-reset x_post0", x_post0, 16'h0200);
    check("post-reset P_post00", P_post00, 16'h0100);

    // Randomized frames against the model.
    for (int f = 0; f < 12; f++) begin
      load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      run_frame(lat);
      check("rand latency", lat, 12);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kf_update_semipar.md
Name: kf_update_semipar

Overview:
- 2x2 Kalman measurement-update stage, directly downstream of the Kalman-gain block; consumes its K matrix.
- Computes innovation y = z − H·x_prior, state x_post = x_prior + K·y, covariance P_post = (I − K·H)·P_prior.
- Semi-parallel datapath: 4 fxp_mul (full 2N products) plus two 2N-domain column adders, driven by a fixed 12-step schedule.
- start/done handshake matches the gain stage, so its done can drive this block's start directly.

Parameters:
N, `FXP_N, total signed fixed-point width
FRAC, `FXP_FRAC, fractional bits (ONE = 1<<FRAC)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  frame request; accepted only when busy=0
x_prior0, x_prior1  in  N each  signed prior state
z0, z1  in  N each  signed measurement
h00, h01, h10, h11  in  N each  signed H
K00, K01, K10, K11  in  N each  signed gain from upstream stage
p_prior00, p_prior01, p_prior10, p_prior11  in  N each  signed prior covariance
busy  out  1  frame in progress
done  out  1  one-cycle pulse, all results valid
x_post0, x_post1  out  N each  registered posterior state
P_post00, P_post01, P_post10, P_post11  out  N each  registered posterior covariance

Behaviour:
- Reset: synchronous, active-low. On any rising edge with rst_n=0, clear all of the following to 0 regardless of state:
  - busy, done, cyc
  - all outputs
  - multiplier operand registers, y0/y1, a00..a11
- Reset mid-frame aborts the frame; no done is produced.
- Accept: edge with start=1 and busy=0 sets busy<=1 and cyc<=0. start while busy=1 is ignored, with no queuing.
- Each following edge with busy=1 executes step cyc, then cyc increments. Step 11 also sets busy<=0 and done<=1.
- done is a registered single-cycle pulse, 12 cycles after the accepting edge. done defaults to 0 on every other edge.
- A start sampled in the done cycle (busy=0) is accepted, so back-to-back frames run with a 13-cycle period.
- Inputs must be held stable from the accepting edge through done; the block does not latch them.
- Outputs hold their values until overwritten by a later frame:
  - x_post at step 3.
  - P_post at steps 9 and 11.
- Schedule (muls loaded at even steps, results registered at odd steps):
  - 0: h00·x_prior0, h01·x_prior1, h10·x_prior0, h11·x_prior1
  - 1: y0 <= z0 − T(sum01); y1 <= z1 − T(sum23)
  - 2: K00·y0, K01·y1, K10·y0, K11·y1
  - 3: x_post0 <= x_prior0 + T(sum01); x_post1 <= x_prior1 + T(sum23)
  - 4: K00·h00, K01·h10, K10·h00, K11·h10
  - 5: a00 <= ONE − T(sum01); a10 <= −T(sum23)
  - 6: K00·h01, K01·h11, K10·h01, K11·h11
  - 7: a01 <= −T(sum01); a11 <= ONE − T(sum23)
  - 8: a00·p_prior00, a01·p_prior10, a10·p_prior00, a11·p_prior10
  - 9: P_post00 <= T(sum01); P_post10 <= T(sum23)
  - 10: a00·p_prior01, a01·p_prior11, a10·p_prior01, a11·p_prior11
  - 11: P_post01 <= T(sum01); P_post11 <= T(sum23)
- Arithmetic rules:
  - sum01 = m0+m1 and sum23 = m2+m3, each kept to 2N bits (carry dropped).
  - T(x) = x[FRAC+N−1:FRAC], i.e. floor toward −inf.
  - All N-bit add/subtract wraps two's complement; no saturation, no rounding.
- Single multiplier set: no operand register changes outside even steps.

Test Plan:
- Params N=16, FRAC=8. H=I (0x0100 diag), K=0.5·I (0x0080 diag), x_prior=(0x0100,0x0200), z=(0x0300,0x0200), P_prior=2·I (0x0200 diag) -> done exactly 12 cycles after accept; x_post=(0x0200,0x0200); P_post00=P_post11=0x0100; off-diagonals 0.
- K=0, arbitrary H/z, P_prior=(0x0123,0x0045,0x0045,0x0300) -> x_post=x_prior, P_post=P_prior bit-exact.
- Floor truncation: H=I, K00=0x0080, other K=0, x_prior0=0, z0=0xFFFF -> x_post0=0xFFFF (not 0x0000).
- Wrap: H=I, K=I, x_prior0=0x7F00, z0=0x7F00+0x0200 (wrapped) -> x_post0 wraps identically to the 16-bit two's-complement golden value; no saturation.
- start held high 30 cycles -> accepts at cycles 0, 13 and 26; done at 12 and 25; busy low only in done cycles; a start pulse at step 5 of a frame has no effect.
- rst_n=0 for 1 cycle at step 7 -> busy, done and all outputs read 0 next cycle; no done follows; a new start after reset yields the correct full result.
